// File: rtl/icache_dm_burst_if.sv
// icache_dm_burst_if: fetch-side and bus-side signals of the direct-mapped
// instruction cache, bundled so the cache and its environment share one port.
//   cpu_req/cpu_addr/flush   -> cache   fetch request, byte address, invalidate-all
//   cpu_ready/cpu_insn       <- cache   instruction valid / 32-bit instruction
//   bid/grant                           arbiter request / grant
//   req/reqtag/reqcyc/reqack            line read request and its acceptance
//   resp/resptag/respcyc/respack        response beats and their acceptance
// Modport master is the cache, modport slave is the fetch stage + bus side.
interface icache_dm_burst_if #(
    parameter int BUS_TAG_WIDTH = 13
);
    logic                     cpu_req;
    logic [63:0]              cpu_addr;
    logic                     flush;
    logic                     cpu_ready;
    logic [31:0]              cpu_insn;
    logic                     bid;
    logic                     grant;
    logic [63:0]              req;
    logic [BUS_TAG_WIDTH-1:0] reqtag;
    logic                     reqcyc;
    logic                     reqack;
    logic [63:0]              resp;
    logic [BUS_TAG_WIDTH-1:0] resptag;
    logic                     respcyc;
    logic                     respack;

    modport master (
        input  cpu_req, cpu_addr, flush, grant, reqack, resp, resptag, respcyc,
        output cpu_ready, cpu_insn, bid, req, reqtag, reqcyc, respack
    );

    modport slave (
        output cpu_req, cpu_addr, flush, grant, reqack, resp, resptag, respcyc,
        input  cpu_ready, cpu_insn, bid, req, reqtag, reqcyc, respack
    );
endinterface

// File: rtl/icache_dm_burst.sv
// icache_dm_burst: direct-mapped instruction cache with a line-aligned burst
// fill of LINE_WORDS 64-bit beats. Hits return in the same cycle; a miss bids
// for the bus, issues one read request for the line and collects every beat.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    icache_dm_burst_if.master (fetch side and bus side)
module icache_dm_burst #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_SETS       = 64,
    parameter int LINE_WORDS     = 8
) (
    input  logic                clk,
    input  logic                reset,
    icache_dm_burst_if.master   bus
);
    localparam int OFF   = $clog2(LINE_WORDS * 8);
    localparam int IDX   = $clog2(NUM_SETS);
    localparam int TAG_W = 64 - OFF - IDX;
    localparam int WW    = $clog2(LINE_WORDS);
    // read, memory space, remaining bits zero
    localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG = {1'b1, 4'b0001, {(BUS_TAG_WIDTH-5){1'b0}}};

    typedef enum logic [1:0] {IDLE, BID, REQ, FILL} state_t;

    state_t              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic                abort_pend_q, abort_pend_d;
    logic [WW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [63:0]         miss_addr_q, miss_addr_d;

    // Storage arrays carry no reset; valid_q alone decides what may hit.
    logic [TAG_W-1:0]          tag_mem  [NUM_SETS];
    logic [BUS_DATA_WIDTH-1:0] data_mem [NUM_SETS][LINE_WORDS];

    logic [IDX-1:0]            cpu_idx, miss_idx;
    logic [TAG_W-1:0]          cpu_tag;
    logic [WW-1:0]             cpu_word;
    logic [BUS_DATA_WIDTH-1:0] hit_word;
    logic                      hit;
    logic                      beat_we, tag_we;

    logic                      cpu_ready, bid, reqcyc, respack;
    logic [63:0]               req;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;

    logic unused_ok;
    assign unused_ok = ^{bus.cpu_addr[1:0], bus.resptag};

    assign cpu_idx  = bus.cpu_addr[OFF+IDX-1:OFF];
    assign cpu_tag  = bus.cpu_addr[63:OFF+IDX];
    assign cpu_word = bus.cpu_addr[OFF-1:3];
    assign miss_idx = miss_addr_q[OFF+IDX-1:OFF];
    assign hit      = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign hit_word = data_mem[cpu_idx][cpu_word];

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        abort_pend_d = abort_pend_q;
        beat_cnt_d   = beat_cnt_q;
        miss_addr_d  = miss_addr_q;
        cpu_ready    = 1'b0;
        bid          = 1'b0;
        req          = '0;
        reqtag       = '0;
        reqcyc       = 1'b0;
        respack      = 1'b0;
        beat_we      = 1'b0;
        tag_we       = 1'b0;

        // Flush always wipes every valid bit; mid-miss it also poisons the
        // line being filled so it completes on the bus but never turns valid.
        if (bus.flush) begin
            valid_d = '0;
            if (state_q != IDLE) abort_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cpu_ready = bus.cpu_req && hit && !bus.flush;
                if (!bus.flush && bus.cpu_req && !hit) begin
                    miss_addr_d      = {bus.cpu_addr[63:OFF], {OFF{1'b0}}};
                    // Victim goes invalid now so a half-written line cannot hit.
                    valid_d[cpu_idx] = 1'b0;
                    state_d          = BID;
                end
            end
            BID: begin
                bid = 1'b1;
                if (bus.grant) state_d = REQ;
            end
            REQ: begin
                bid    = 1'b1;
                reqcyc = 1'b1;
                req    = miss_addr_q;
                reqtag = REQ_TAG;
                if (bus.reqack) begin
                    beat_cnt_d = '0;
                    state_d    = FILL;
                end
            end
            FILL: begin
                bid     = 1'b1;
                respack = bus.respcyc;
                if (bus.respcyc) begin
                    beat_we    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == WW'(LINE_WORDS - 1)) begin
                        tag_we            = 1'b1;
                        // A flush on the final beat aborts the line just the same.
                        valid_d[miss_idx] = !(abort_pend_q || bus.flush);
                        abort_pend_d      = 1'b0;
                        state_d           = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            abort_pend_q <= 1'b0;
            beat_cnt_q   <= '0;
            miss_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            abort_pend_q <= abort_pend_d;
            beat_cnt_q   <= beat_cnt_d;
            miss_addr_q  <= miss_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_we) data_mem[miss_idx][beat_cnt_q] <= bus.resp;
        if (tag_we)  tag_mem[miss_idx] <= miss_addr_q[63:OFF+IDX];
    end

    assign bus.cpu_ready = cpu_ready;
    assign bus.cpu_insn  = !hit ? 32'h0 :
                           bus.cpu_addr[2] ? hit_word[63:32] : hit_word[31:0];
    assign bus.bid       = bid;
    assign bus.req       = req;
    assign bus.reqtag    = reqtag;
    assign bus.reqcyc    = reqcyc;
    assign bus.respack   = respack;
endmodule

// File: tb/tb_icache_dm_burst.sv
// Bench for icache_dm_burst at default geometry (64 sets, 8 beats per line).
// A bus model answers bid/request/beats with programmable delays; the stimulus
// pushes expected instructions and request addresses into queues that a
// negedge monitor drains whenever the DUT presents cpu_ready or a request.
module tb_icache_dm_burst;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_dm_burst_if #(.BUS_TAG_WIDTH(13)) bus ();

    icache_dm_burst #(
        .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .NUM_SETS(64), .LINE_WORDS(LW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int nvec  = 0;
    int nfail = 0;
    logic [31:0] exp_insn_q [$];
    logic [63:0] exp_req_q  [$];
    logic [63:0] beat_data  [LW];
    logic [31:0] sweep_exp  [16];
    int g_dly    = 0;
    int a_dly    = 0;
    int gap      = 0;
    int cur_beat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cold();
        for (int i = 0; i < LW; i++) beat_data[i] = 64'(17 * (i + 1));
    endtask

    task automatic set_beats(input logic [31:0] hi, input logic [31:0] lo);
        for (int i = 0; i < LW; i++) beat_data[i] = {hi + 32'(i), lo + 32'(i)};
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, " cpu_ready"}, 64'(bus.cpu_ready), 64'h0);
        chk({tag, " cpu_insn"},  64'(bus.cpu_insn),  64'h0);
        chk({tag, " bid"},       64'(bus.bid),       64'h0);
        chk({tag, " reqcyc"},    64'(bus.reqcyc),    64'h0);
        chk({tag, " req"},       bus.req,            64'h0);
        chk({tag, " reqtag"},    64'(bus.reqtag),    64'h0);
        chk({tag, " respack"},   64'(bus.respack),   64'h0);
    endtask

    // Holds cpu_req on addr a until cpu_ready; exp_lat > 0 means a miss whose
    // line request must carry exp_req.
    task automatic access(input logic [63:0] a, input logic [31:0] exp,
                          input int exp_lat, input logic [63:0] exp_req);
        int c;
        bit got;
        if (exp_lat > 0) exp_req_q.push_back(exp_req);
        exp_insn_q.push_back(exp);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        c   = 0;
        got = 1'b0;
        while (!got && c < 200) begin
            #1;
            if (bus.cpu_ready) got = 1'b1;
            else begin
                step();
                c++;
            end
        end
        chk($sformatf("latency @%0h", a), 64'(c), 64'(exp_lat));
        if (got) step();
    endtask

    task automatic wait_beat(input int b);
        int c = 0;
        while (cur_beat != b && c < 100) begin
            step();
            c++;
        end
        chk($sformatf("reached beat %0d", b), 64'(cur_beat), 64'(b));
    endtask

    // Bus side: grant after g_dly cycles of bid, ack after a_dly cycles of
    // reqcyc, then LW beats separated by gap idle cycles.
    initial begin
        int bst, cnt, gcnt, beat;
        bst = 0; cnt = 0; gcnt = 0; beat = 0;
        bus.grant = 1'b0; bus.reqack = 1'b0; bus.respcyc = 1'b0;
        bus.resp = '0; bus.resptag = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.grant = 1'b0; bus.reqack = 1'b0; bus.respcyc = 1'b0;
            bus.resp = '0; bus.resptag = '0;
            cur_beat = -1;
            if (reset) begin
                bst = 0; cnt = 0; gcnt = 0; beat = 0;
            end else if (bst == 0) begin
                if (bus.reqcyc) begin
                    if (cnt >= a_dly) begin
                        bus.reqack = 1'b1; cnt = 0; bst = 1; gcnt = gap;
                    end else cnt++;
                end else if (bus.bid) begin
                    if (cnt >= g_dly) begin
                        bus.grant = 1'b1; cnt = 0;
                    end else cnt++;
                end
            end else begin
                if (gcnt >= gap) begin
                    bus.respcyc = 1'b1;
                    bus.resp    = beat_data[beat];
                    bus.resptag = 13'h1100;
                    cur_beat    = beat;
                    gcnt        = 0;
                    beat++;
                    if (beat == LW) begin
                        beat = 0; bst = 0;
                    end
                end else gcnt++;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents something.
    always @(negedge clk) begin
        if (bus.cpu_ready) begin
            if (exp_insn_q.size() == 0) chk("cpu_ready with empty scoreboard", 64'(bus.cpu_ready), 64'h0);
            else chk("cpu_insn", 64'(bus.cpu_insn), 64'(exp_insn_q.pop_front()));
        end
        if (bus.reqcyc && bus.reqack) begin
            if (exp_req_q.size() == 0) chk("request with empty scoreboard", 64'(bus.reqcyc), 64'h0);
            else chk("req addr", bus.req, exp_req_q.pop_front());
            chk("reqtag", 64'(bus.reqtag), 64'h1100);
        end
        if (!reset && (bus.respcyc || bus.respack))
            chk("respack follows respcyc", 64'(bus.respack), 64'(bus.respcyc));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sweep_exp = '{32'h11, 32'h0, 32'h22, 32'h0, 32'h33, 32'h0, 32'h44, 32'h0,
                      32'h55, 32'h0, 32'h66, 32'h0, 32'h77, 32'h0, 32'h88, 32'h0};
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
        set_cold();
        repeat (3) @(posedge clk);
        #2;
        bus.cpu_req = 1'b1;
        #1;
        outputs_zero("in reset");
        bus.cpu_req = 1'b0;
        reset = 1'b0;
        step();

        // cold miss, then hits in both halves of word 0
        access(64'h1000, 32'h11, 11, 64'h1000);
        access(64'h1004, 32'h0, 0, 64'h0);

        // hit sweep over the whole line: ready every cycle, no bus bid
        for (int k = 0; k < 16; k++) begin
            access(64'h1000 + 64'(4 * k), sweep_exp[k], 0, 64'h0);
            chk("bid during hit sweep", 64'(bus.bid), 64'h0);
        end

        // flush in IDLE masks a hit, then the line misses again
        bus.cpu_addr = 64'h1000; bus.cpu_req = 1'b1; bus.flush = 1'b1;
        #1;
        chk("cpu_ready under flush", 64'(bus.cpu_ready), 64'h0);
        step();
        bus.flush = 1'b0;
        set_beats(32'hA000_0000, 32'hB000_0000);
        access(64'h1000, 32'hB000_0000, 11, 64'h1000);

        // flush and miss in the same IDLE cycle: no fill starts
        bus.cpu_addr = 64'h7000; bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.cpu_req = 1'b0;
        #1;
        chk("bid after flush+miss", 64'(bus.bid), 64'h0);
        access(64'h7008, 32'hB000_0001, 11, 64'h7000);

        // conflict on index 0, unaligned addresses, aligned requests
        set_beats(32'hC000_0000, 32'hD000_0000);
        access(64'h2014, 32'hC000_0002, 11, 64'h2000);
        access(64'h1038, 32'hD000_0007, 11, 64'h1000);
        bus.cpu_req = 1'b0;
        step();

        // back-pressure: grant +3, reqack +2, one idle cycle between beats
        set_beats(32'hE000_0000, 32'hF000_0000);
        g_dly = 3; a_dly = 2; gap = 1;
        access(64'h4084, 32'hE000_0000, 23, 64'h4080);
        g_dly = 0; a_dly = 0; gap = 0;
        access(64'h40BC, 32'hE000_0007, 0, 64'h0);

        // flush during beat 4: line completes invalid, other lines drop too
        set_beats(32'h1234_0000, 32'h5678_0000);
        exp_req_q.push_back(64'h1040);
        bus.cpu_addr = 64'h1040; bus.cpu_req = 1'b1;
        step();
        bus.cpu_req = 1'b0;
        wait_beat(4);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int c = 0; c < 50 && bus.bid; c++) step();
        chk("fill ends after flush", 64'(bus.bid), 64'h0);
        access(64'h1040, 32'h5678_0000, 11, 64'h1040);
        access(64'h4084, 32'h1234_0000, 11, 64'h4080);

        // reset in the middle of a fill
        set_cold();
        exp_req_q.push_back(64'h1000);
        bus.cpu_addr = 64'h1000; bus.cpu_req = 1'b1;
        wait_beat(3);
        reset = 1'b1;
        #1;
        outputs_zero("reset mid-fill");
        step();
        step();
        reset = 1'b0;
        access(64'h1000, 32'h11, 11, 64'h1000);

        bus.cpu_req = 1'b0;
        repeat (3) step();
        chk("insn scoreboard drained", 64'(exp_insn_q.size()), 64'h0);
        chk("req scoreboard drained", 64'(exp_req_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
